// File: rtl/rename_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rename_pkg                                         |
// | Description : Shared sizes, register/checkpoint ids and the      |
// |               registered rename result bundle.                   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package rename_pkg;

   localparam int ARCH_REGS_DEF = 32;
   localparam int PHYS_REGS_DEF = 64;
   localparam int CKPTS_DEF     = 4;

   typedef logic [$clog2(PHYS_REGS_DEF)-1:0] PhysReg_t;
   typedef logic [$clog2(CKPTS_DEF)-1:0]     CkptId_t;

   typedef struct packed {
      logic     valid;
      PhysReg_t rs_phys;
      PhysReg_t rt_phys;
      PhysReg_t rd_phys;
      PhysReg_t old_phys;
      logic     rs_busy;
      logic     rt_busy;
      CkptId_t  ckpt_id;
   } RenameOut_t;

endpackage
`default_nettype wire

// File: rtl/rename_free_list.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rename_free_list                                   |
// | Description : Circular free physical register list with a wrap   |
// |               bit on each pointer and head-pointer restore.      |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module rename_free_list
   import rename_pkg::*;
#(
   parameter int   ARCH_REGS = ARCH_REGS_DEF,
   parameter int   PHYS_REGS = PHYS_REGS_DEF,
   localparam int  C_DEPTH   = PHYS_REGS - ARCH_REGS,
   localparam int  C_IDX_W   = $clog2(C_DEPTH),
   localparam int  C_PTR_W   = C_IDX_W + 1
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pop_i,
   output PhysReg_t           head_data_o,
   input  logic               push_i,
   input  PhysReg_t           push_data_i,
   output logic [C_PTR_W-1:0] rd_ptr_next_o,
   input  logic               restore_i,
   input  logic [C_PTR_W-1:0] restore_ptr_i,
   output logic               empty_o
);

   PhysReg_t           mem_q [C_DEPTH];
   logic [C_PTR_W-1:0] head_q;
   logic [C_PTR_W-1:0] tail_q;

   function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
      if (p[C_IDX_W-1:0] == C_IDX_W'(C_DEPTH - 1))
         return {~p[C_PTR_W-1], {C_IDX_W{1'b0}}};
      return {p[C_PTR_W-1], p[C_IDX_W-1:0] + 1'b1};
   endfunction

   assign empty_o       = (head_q == tail_q);
   assign head_data_o   = mem_q[head_q[C_IDX_W-1:0]];
   assign rd_ptr_next_o = pop_i ? ptr_inc(head_q) : head_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < C_DEPTH; i++)
            mem_q[i] <= PhysReg_t'(ARCH_REGS + i);
         head_q <= '0;
         // Full list: tail sits one lap ahead of head.
         tail_q <= {1'b1, {C_IDX_W{1'b0}}};
      end else begin
         if (push_i) begin
            mem_q[tail_q[C_IDX_W-1:0]] <= push_data_i;
            tail_q                     <= ptr_inc(tail_q);
         end
         if (restore_i)
            head_q <= restore_ptr_i;
         else if (pop_i)
            head_q <= ptr_inc(head_q);
      end
   end

endmodule
`default_nettype wire

// File: rtl/rename_ckpt_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rename_ckpt_unit                                   |
// | Description : Register rename with busy table and age-ordered    |
// |               branch checkpoints. Option: RENAME_WB_BYPASS_EN.   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module rename_ckpt_unit
   import rename_pkg::*;
#(
   parameter int  ARCH_REGS = ARCH_REGS_DEF,
   parameter int  PHYS_REGS = PHYS_REGS_DEF,
   parameter int  CKPTS     = CKPTS_DEF,
   localparam int C_AW      = $clog2(ARCH_REGS),
   localparam int C_PW      = $clog2(PHYS_REGS),
   localparam int C_CW      = $clog2(CKPTS),
   localparam int C_FL_PTR_W = $clog2(PHYS_REGS - ARCH_REGS) + 1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ren_valid,
   output logic            ren_ready,
   input  logic [C_AW-1:0] ren_rs,
   input  logic [C_AW-1:0] ren_rt,
   input  logic            ren_uses_rw,
   input  logic [C_AW-1:0] ren_rw,
   input  logic            ren_is_branch,
   output logic            out_valid,
   output logic [C_PW-1:0] out_rs_phys,
   output logic [C_PW-1:0] out_rt_phys,
   output logic [C_PW-1:0] out_rd_phys,
   output logic [C_PW-1:0] out_old_phys,
   output logic            out_rs_busy,
   output logic            out_rt_busy,
   output logic [C_CW-1:0] out_ckpt_id,
   input  logic            wb_valid,
   input  logic [C_PW-1:0] wb_phys,
   input  logic            commit_valid,
   input  logic [C_PW-1:0] commit_old_phys,
   input  logic            recover_valid,
   input  logic [C_CW-1:0] recover_ckpt,
   input  logic            release_valid,
   input  logic [C_CW-1:0] release_ckpt
);

   PhysReg_t               map_q [ARCH_REGS];
   PhysReg_t               map_d [ARCH_REGS];
   logic [PHYS_REGS-1:0]   busy_q, busy_d;
   logic [CKPTS-1:0]       ckpt_valid_q, ckpt_valid_d;
   // younger_q[i][j] set when checkpoint j was taken while i was live
   logic [CKPTS-1:0]       younger_q [CKPTS];
   PhysReg_t               ckpt_map_q [CKPTS][ARCH_REGS];
   logic [C_FL_PTR_W-1:0]  ckpt_ptr_q [CKPTS];
   RenameOut_t             out_q;

   logic                   w_fl_empty;
   PhysReg_t               w_fl_head;
   logic [C_FL_PTR_W-1:0]  w_fl_ptr_next;
   logic                   w_ckpt_free;
   CkptId_t                w_free_id;
   logic                   w_accept, w_alloc, w_branch;
   PhysReg_t               w_rs_phys, w_rt_phys, w_cur_rw;
   logic                   w_rs_busy, w_rt_busy;

   rename_free_list #(
      .ARCH_REGS (ARCH_REGS),
      .PHYS_REGS (PHYS_REGS)
   ) u_free_list (
      .clk           (clk),
      .rst_n         (rst_n),
      .pop_i         (w_alloc),
      .head_data_o   (w_fl_head),
      .push_i        (commit_valid),
      .push_data_i   (commit_old_phys),
      .rd_ptr_next_o (w_fl_ptr_next),
      .restore_i     (recover_valid),
      .restore_ptr_i (ckpt_ptr_q[recover_ckpt]),
      .empty_o       (w_fl_empty)
   );

   always_comb begin
      w_ckpt_free = 1'b0;
      w_free_id   = '0;
      for (int i = CKPTS - 1; i >= 0; i--) begin
         if (!ckpt_valid_q[i]) begin
            w_ckpt_free = 1'b1;
            w_free_id   = CkptId_t'(i);
         end
      end
   end

   assign ren_ready = !w_fl_empty && (!ren_is_branch || w_ckpt_free) && !recover_valid;
   assign w_accept  = ren_valid && ren_ready;
   assign w_alloc   = w_accept && ren_uses_rw && (ren_rw != '0);
   assign w_branch  = w_accept && ren_is_branch;

   assign w_rs_phys = map_q[ren_rs];
   assign w_rt_phys = map_q[ren_rt];
   assign w_cur_rw  = map_q[ren_rw];

`ifdef RENAME_WB_BYPASS_EN
   assign w_rs_busy = busy_q[w_rs_phys] && !(wb_valid && (wb_phys == w_rs_phys));
   assign w_rt_busy = busy_q[w_rt_phys] && !(wb_valid && (wb_phys == w_rt_phys));
`else
   assign w_rs_busy = busy_q[w_rs_phys];
   assign w_rt_busy = busy_q[w_rt_phys];
`endif

   always_comb begin
      for (int i = 0; i < ARCH_REGS; i++)
         map_d[i] = map_q[i];
      if (recover_valid) begin
         for (int i = 0; i < ARCH_REGS; i++)
            map_d[i] = ckpt_map_q[recover_ckpt][i];
      end else if (w_alloc) begin
         map_d[ren_rw] = w_fl_head;
      end
   end

   // A set from allocation overrides a same-cycle writeback clear.
   always_comb begin
      busy_d = busy_q;
      if (wb_valid)
         busy_d[wb_phys] = 1'b0;
      if (w_alloc)
         busy_d[w_fl_head] = 1'b1;
   end

   always_comb begin
      ckpt_valid_d = ckpt_valid_q;
      if (release_valid)
         ckpt_valid_d[release_ckpt] = 1'b0;
      if (recover_valid)
         ckpt_valid_d = ckpt_valid_d & ~(younger_q[recover_ckpt] | (CKPTS'(1) << recover_ckpt));
      if (w_branch)
         ckpt_valid_d[w_free_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ARCH_REGS; i++)
            map_q[i] <= PhysReg_t'(i);
         for (int i = 0; i < CKPTS; i++)
            younger_q[i] <= '0;
         busy_q       <= '0;
         ckpt_valid_q <= '0;
         out_q        <= '0;
      end else begin
         for (int i = 0; i < ARCH_REGS; i++)
            map_q[i] <= map_d[i];
         busy_q       <= busy_d;
         ckpt_valid_q <= ckpt_valid_d;
         if (w_branch) begin
            younger_q[w_free_id] <= '0;
            for (int j = 0; j < CKPTS; j++)
               if (CkptId_t'(j) != w_free_id)
                  younger_q[j][w_free_id] <= ckpt_valid_q[j];
         end
         out_q.valid <= w_accept;
         if (w_accept) begin
            out_q.rs_phys  <= w_rs_phys;
            out_q.rt_phys  <= w_rt_phys;
            out_q.rd_phys  <= w_alloc ? w_fl_head : w_cur_rw;
            out_q.old_phys <= w_cur_rw;
            out_q.rs_busy  <= w_rs_busy;
            out_q.rt_busy  <= w_rt_busy;
            out_q.ckpt_id  <= ren_is_branch ? w_free_id : '0;
         end
      end
   end

   // Snapshot holds the map after the branch's own destination update.
   always_ff @(posedge clk) begin
      if (w_branch) begin
         for (int i = 0; i < ARCH_REGS; i++)
            ckpt_map_q[w_free_id][i] <= map_d[i];
         ckpt_ptr_q[w_free_id] <= w_fl_ptr_next;
      end
   end

   assign out_valid    = out_q.valid;
   assign out_rs_phys  = out_q.rs_phys;
   assign out_rt_phys  = out_q.rt_phys;
   assign out_rd_phys  = out_q.rd_phys;
   assign out_old_phys = out_q.old_phys;
   assign out_rs_busy  = out_q.rs_busy;
   assign out_rt_busy  = out_q.rt_busy;
   assign out_ckpt_id  = out_q.ckpt_id;

endmodule
`default_nettype wire

// File: tb/tb_rename_ckpt_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_rename_ckpt_unit                                |
// | Description : Directed self-checking bench for rename_ckpt_unit. |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module tb_rename_ckpt_unit;

`ifdef RENAME_WB_BYPASS_EN
   localparam int C_BYP_BUSY = 0;
`else
   localparam int C_BYP_BUSY = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ren_valid, ren_ready, ren_uses_rw, ren_is_branch;
   logic [4:0] ren_rs, ren_rt, ren_rw;
   logic       out_valid, out_rs_busy, out_rt_busy;
   logic [5:0] out_rs_phys, out_rt_phys, out_rd_phys, out_old_phys;
   logic [1:0] out_ckpt_id;
   logic       wb_valid, commit_valid, recover_valid, release_valid;
   logic [5:0] wb_phys, commit_old_phys;
   logic [1:0] recover_ckpt, release_ckpt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rename_ckpt_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ren_valid       (ren_valid),
      .ren_ready       (ren_ready),
      .ren_rs          (ren_rs),
      .ren_rt          (ren_rt),
      .ren_uses_rw     (ren_uses_rw),
      .ren_rw          (ren_rw),
      .ren_is_branch   (ren_is_branch),
      .out_valid       (out_valid),
      .out_rs_phys     (out_rs_phys),
      .out_rt_phys     (out_rt_phys),
      .out_rd_phys     (out_rd_phys),
      .out_old_phys    (out_old_phys),
      .out_rs_busy     (out_rs_busy),
      .out_rt_busy     (out_rt_busy),
      .out_ckpt_id     (out_ckpt_id),
      .wb_valid        (wb_valid),
      .wb_phys         (wb_phys),
      .commit_valid    (commit_valid),
      .commit_old_phys (commit_old_phys),
      .recover_valid   (recover_valid),
      .recover_ckpt    (recover_ckpt),
      .release_valid   (release_valid),
      .release_ckpt    (release_ckpt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      ren_valid       = 1'b0;
      ren_rs          = '0;
      ren_rt          = '0;
      ren_rw          = '0;
      ren_uses_rw     = 1'b0;
      ren_is_branch   = 1'b0;
      wb_valid        = 1'b0;
      wb_phys         = '0;
      commit_valid    = 1'b0;
      commit_old_phys = '0;
      recover_valid   = 1'b0;
      recover_ckpt    = '0;
      release_valid   = 1'b0;
      release_ckpt    = '0;
   endtask

   // A rename request held during reset must leave no trace afterwards.
   task automatic do_reset;
      clear_inputs();
      rst_n       = 1'b0;
      ren_valid   = 1'b1;
      ren_uses_rw = 1'b1;
      ren_rw      = 5'd5;
      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_rd", 32'(out_rd_phys), 0);
      clear_inputs();
      rst_n = 1'b1;
      #1;
      check("rst_ready", 32'(ren_ready), 1);
   endtask

   // Side inputs (wb/commit/recover/release) set by the caller share this cycle.
   task automatic ren(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                      input logic uses, input logic br);
      ren_valid     = 1'b1;
      ren_rs        = rs;
      ren_rt        = rt;
      ren_rw        = rw;
      ren_uses_rw   = uses;
      ren_is_branch = br;
      tick();
      clear_inputs();
   endtask

   initial begin
      // Basic allocation, no-alloc paths and busy tracking
      do_reset();
      ren(5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
      check("a_valid", 32'(out_valid), 1);
      check("a_rs", 32'(out_rs_phys), 5);
      check("a_rd", 32'(out_rd_phys), 32);
      check("a_old", 32'(out_old_phys), 5);
      tick();
      check("a_valid_pulse", 32'(out_valid), 0);
      ren(5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
      check("a_rs_new", 32'(out_rs_phys), 32);
      check("a_rs_busy32", 32'(out_rs_busy), 1);
      check("a_rt_busy0", 32'(out_rt_busy), 0);
      check("a_noalloc_rd", 32'(out_rd_phys), 32);
      check("a_noalloc_old", 32'(out_old_phys), 32);
      ren(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      check("a_rw0_rd", 32'(out_rd_phys), 0);
      check("a_rw0_old", 32'(out_old_phys), 0);
      ren(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
      check("a_rw0_nopop", 32'(out_rd_phys), 33);
      wb_valid = 1'b1;
      wb_phys  = 6'd32;
      ren(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
      check("a_wb_bypass", 32'(out_rs_busy), C_BYP_BUSY);
      ren(5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
      check("a_wb_cleared", 32'(out_rs_busy), 0);
      wb_valid = 1'b1;
      wb_phys  = 6'd34;
      ren(5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
      check("a_rd34", 32'(out_rd_phys), 34);
      ren(5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
      check("a_set_wins_phys", 32'(out_rs_phys), 34);
      check("a_set_wins_busy", 32'(out_rs_busy), 1);

      // Exhaust the free list, then refill via commit
      do_reset();
      for (int i = 0; i < 32; i++) begin
         ren(5'd0, 5'd0, 5'((i % 31) + 1), 1'b1, 1'b0);
         check("b_drain_rd", 32'(out_rd_phys), 32'(32 + i));
      end
      ren_valid   = 1'b1;
      ren_uses_rw = 1'b1;
      ren_rw      = 5'd6;
      #1;
      check("b_empty_ready", 32'(ren_ready), 0);
      tick();
      clear_inputs();
      check("b_empty_noaccept", 32'(out_valid), 0);
      commit_valid    = 1'b1;
      commit_old_phys = 6'd7;
      tick();
      clear_inputs();
      #1;
      check("b_refill_ready", 32'(ren_ready), 1);
      ren(5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
      check("b_reuse7", 32'(out_rd_phys), 7);
      commit_valid    = 1'b1;
      commit_old_phys = 6'd9;
      tick();
      clear_inputs();
      commit_valid    = 1'b1;
      commit_old_phys = 6'd11;
      ren(5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
      check("b_pushpop_rd", 32'(out_rd_phys), 9);
      ren(5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
      check("b_pushpop_next", 32'(out_rd_phys), 11);
      #1;
      check("b_empty_again", 32'(ren_ready), 0);

      // Checkpoint, misprediction rollback, commit during recovery
      do_reset();
      ren(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
      check("c_rd32", 32'(out_rd_phys), 32);
      ren(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      check("c_br_valid", 32'(out_valid), 1);
      check("c_br_ckpt0", 32'(out_ckpt_id), 0);
      ren(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
      check("c_rd33", 32'(out_rd_phys), 33);
      check("c_old3", 32'(out_old_phys), 3);
      recover_valid   = 1'b1;
      recover_ckpt    = 2'd0;
      commit_valid    = 1'b1;
      commit_old_phys = 6'd7;
      ren_valid       = 1'b1;
      ren_uses_rw     = 1'b1;
      ren_rw          = 5'd4;
      #1;
      check("c_recover_ready", 32'(ren_ready), 0);
      tick();
      clear_inputs();
      check("c_recover_noaccept", 32'(out_valid), 0);
      ren(5'd3, 5'd5, 5'd3, 1'b1, 1'b0);
      check("c_map3_restored", 32'(out_rs_phys), 3);
      check("c_map5_kept", 32'(out_rt_phys), 32);
      check("c_realloc33", 32'(out_rd_phys), 33);
      check("c_old3_again", 32'(out_old_phys), 3);
      for (int i = 0; i < 30; i++) begin
         ren(5'd0, 5'd0, 5'(i + 1), 1'b1, 1'b0);
         check("c_fill_rd", 32'(out_rd_phys), 32'(34 + i));
      end
      ren(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
      check("c_commit_in_recover", 32'(out_rd_phys), 7);
      #1;
      check("c_final_empty", 32'(ren_ready), 0);

      // Checkpoint exhaustion, release and age-ordered recovery
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ren(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
         check("d_ckpt_id", 32'(out_ckpt_id), 32'(i));
      end
      ren_valid     = 1'b1;
      ren_is_branch = 1'b1;
      #1;
      check("d_br_stall", 32'(ren_ready), 0);
      ren_is_branch = 1'b0;
      #1;
      check("d_nonbr_ready", 32'(ren_ready), 1);
      ren_valid     = 1'b0;
      release_valid = 1'b1;
      release_ckpt  = 2'd2;
      tick();
      clear_inputs();
      ren(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      check("d_reuse_ckpt2", 32'(out_ckpt_id), 2);
      recover_valid = 1'b1;
      recover_ckpt  = 2'd1;
      release_valid = 1'b1;
      release_ckpt  = 2'd1;
      tick();
      clear_inputs();
      for (int i = 1; i < 4; i++) begin
         ren(5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
         check("d_after_recover_id", 32'(out_ckpt_id), 32'(i));
      end
      ren_valid     = 1'b1;
      ren_is_branch = 1'b1;
      #1;
      check("d_ckpt0_still_held", 32'(ren_ready), 0);
      clear_inputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rename_ckpt_unit.md
RENAME_CKPT_UNIT -- requirements
Module: rename_ckpt_unit

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32: architectural register count.
REQ-002 SHALL have parameter PHYS_REGS, default 64: physical register count, greater than ARCH_REGS.
REQ-003 SHALL have parameter CKPTS, default 4: number of branch checkpoints.
REQ-004 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset); one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports ren_valid (in, 1), ren_ready (out, 1), ren_rs and ren_rt (in, log2 ARCH_REGS each), ren_uses_rw (in, 1), ren_rw (in, log2 ARCH_REGS), ren_is_branch (in, 1).
REQ-006 SHALL have ports out_valid (out, 1), out_rs_phys, out_rt_phys, out_rd_phys and out_old_phys (out, log2 PHYS_REGS each), out_rs_busy and out_rt_busy (out, 1 each), out_ckpt_id (out, log2 CKPTS).
REQ-007 SHALL have ports wb_valid (in, 1) and wb_phys (in, log2 PHYS_REGS), which clear a busy bit.
REQ-008 SHALL have ports commit_valid (in, 1) and commit_old_phys (in, log2 PHYS_REGS), which free a register.
REQ-009 SHALL have ports recover_valid (in, 1) and recover_ckpt (in, log2 CKPTS) for mispredict rollback, plus release_valid (in, 1) and release_ckpt (in, log2 CKPTS) for correct-branch release.

Function
REQ-010 SHALL accept a rename when ren_valid and ren_ready are both high in the same cycle.
REQ-011 SHALL drive ren_ready as: free list not empty, AND (not ren_is_branch OR a checkpoint is free), AND not recover_valid; computed from pre-cycle state only.
REQ-012 SHALL read out_rs_phys and out_rt_phys from the map table before that instruction's own destination update.
REQ-013 SHALL, when ren_uses_rw is high and ren_rw is nonzero, pop the free list head into out_rd_phys, return the prior mapping on out_old_phys, update the map table, and set the busy bit of out_rd_phys.
REQ-014 SHALL NOT allocate when ren_rw is 0 or ren_uses_rw is low; out_rd_phys and out_old_phys then equal the current map of ren_rw.
REQ-015 SHALL register all out_* signals one cycle after acceptance, with out_valid high for exactly that one cycle.
REQ-016 SHALL, on an accepted branch, snapshot the map table and the free-list read pointer into the lowest-numbered free checkpoint, and report its index on out_ckpt_id.
REQ-017 SHALL, on commit_valid, push commit_old_phys onto the free-list tail; a push and a pop in the same cycle SHALL both take effect.
REQ-018 SHALL, on wb_valid, clear busy[wb_phys]; a set and a clear of the same index in one cycle SHALL leave the bit set.
REQ-019 SHALL, on recover_valid, restore the map table and free-list read pointer from recover_ckpt, and free that checkpoint and every checkpoint allocated after it (age-ordered).
REQ-020 SHALL, on release_valid, free release_ckpt only.
REQ-021 SHALL give recovery priority over release of the same checkpoint; a commit arriving in the same cycle as a recovery SHALL still be applied.
REQ-022 SHALL use a free list with wrap-around pointers, PHYS_REGS-ARCH_REGS deep, and keep one extra pointer bit to distinguish full from empty.

Reset
REQ-023 SHALL, while rst_n is low at a clock edge: set the map table to identity; load the free list with ARCH_REGS..PHYS_REGS-1 in order; clear all busy bits; free all checkpoints; drive all out_* signals to 0.
REQ-024 SHALL allow reset to abort any in-flight operation, with no output effect in the following cycle.

Configuration
REQ-025 SHALL, with RENAME_WB_BYPASS_EN defined, forward a same-cycle wb_phys match so that out_rs_busy and out_rt_busy read 0.
REQ-026 SHALL, without RENAME_WB_BYPASS_EN, report pre-cycle busy state only.

Structure
REQ-027 SHALL take ARCH_REGS/PHYS_REGS defaults, the PhysReg_t and CkptId_t typedefs, and the rename output struct from shared package rename_pkg.
REQ-028 SHALL implement the free list in sub-module rename_free_list, with push/pop, pointer read, and pointer restore.

Verification
REQ-029 SHALL cover: after reset, rename rw=5, rs=5 -> out_rs_phys=5, out_rd_phys=32, out_old_phys=5, busy[32]=1.
REQ-030 SHALL cover: 32 renames with no commit -> ren_ready=0 on the 33rd; one commit of phys 7 -> the next rename gets phys 7.
REQ-031 SHALL cover: a branch takes ckpt 0, then rw=3 is renamed to 33; recover ckpt 0 -> map[3]=3 and the next allocation is 33 again.
REQ-032 SHALL cover: 4 unreleased branches -> a 5th branch is stalled; release ckpt 2 -> the 5th branch gets ckpt 2.
REQ-033 SHALL cover: wb_phys=32 in the same cycle as renaming rs=rw-mapped-to-32 -> out_rs_busy=0 with the macro defined, 1 without.
REQ-034 SHALL cover: rw=0 with ren_uses_rw=1 -> no pop, and free-list count unchanged.
